// File: rtl/pow2_generator.sv
// Serial power-of-two generator: a one-hot register starts at 1 and
// shifts left once per clock until 2^exponent is reached.
module pow2_generator #(
  parameter int EXP_W = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [EXP_W-1:0] count_q;
  logic [OUT_W-1:0] result_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;
  logic             illegal;

  // When OUT_W covers every encodable exponent nothing can be illegal.
  if (OUT_W >= (1 << EXP_W)) begin : g_all_legal
    assign illegal = 1'b0;
  end else begin : g_range_chk
    assign illegal = (exponent >= EXP_W'(OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          if (count_q != '0) begin
            result_q <= result_q << 1;
            count_q  <= count_q - EXP_W'(1);
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (illegal) begin
              result_q <= '0;
              err_q    <= 1'b1;
              state_q  <= DONE;
              done_q   <= 1'b1;
            end else begin
              result_q <= OUT_W'(1);
              err_q    <= 1'b0;
              count_q  <= exponent;
              state_q  <= SHIFT;
              busy_q   <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_pow2_generator.sv
// Bench for pow2_generator: default 3/8 instance plus a 3/4 instance
// for the out-of-range exponent path.
module tb_pow2_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [2:0] exponent = '0;
  logic       busy, done, err;
  logic [7:0] result;

  logic       start4 = 1'b0;
  logic [2:0] exp4 = '0;
  logic       busy4, done4, err4;
  logic [3:0] result4;

  int nchk  = 0;
  int nfail = 0;

  typedef struct {
    logic [7:0] res;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pow2_generator #(.EXP_W(3), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  pow2_generator #(.EXP_W(3), .OUT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .exponent(exp4),
    .busy(busy4), .done(done4), .result(result4), .err(err4)
  );

  function automatic int log2_of(input logic [7:0] v);
    int lg = -1;
    for (int b = 0; b < 8; b++)
      if (v[b]) lg = b;
    return lg;
  endfunction

  // Drives one request and waits for done; k = edges after accept, -1 on timeout.
  task automatic launch(input int e, input bit nar, output int k,
                        output int bcnt, output logic [7:0] r,
                        output logic er, output logic bz);
    logic d;
    k = -1; bcnt = 0; r = 'x; er = 'x; bz = 'x;
    @(negedge clk);
    if (nar) begin start4 = 1'b1; exp4 = e[2:0]; end
    else begin start = 1'b1; exponent = e[2:0]; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0; start4 = 1'b0;
      d = nar ? done4 : done;
      if (d) begin
        k  = i;
        r  = nar ? {4'h0, result4} : result;
        er = nar ? err4 : err;
        bz = nar ? busy4 : busy;
        break;
      end
      if (nar ? busy4 : busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, done, result, err} !== 11'h0) begin
      nfail++;
      $display("FAIL reset_outs got b=%b d=%b r=%h e=%b want 0", busy, done, result, err);
    end
    nchk++;
    if ({busy4, done4, result4, err4} !== 7'h0) begin
      nfail++;
      $display("FAIL reset_outs4 got b=%b d=%b r=%h e=%b want 0", busy4, done4, result4, err4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int k, bc; logic [7:0] r; logic er, bz; exp_t x;
    sb.push_back('{8'h01, 1'b0, 1});
    launch(0, 1'b0, k, bc, r, er, bz);
    x = sb.pop_front();
    nchk++;
    if (k !== x.lat || bc !== 1) begin
      nfail++;
      $display("FAIL single_lat got k=%0d busy=%0d want k=%0d busy=1", k, bc, x.lat);
    end
    nchk++;
    if (r !== x.res || er !== x.er) begin
      nfail++;
      $display("FAIL single_res got %h/%b want %h/%b", r, er, x.res, x.er);
    end
    @(negedge clk);
    nchk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL single_pulse got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_sweep;
    int k, bc; logic [7:0] r; logic er, bz; exp_t x;
    for (int e = 0; e < 8; e++) begin
      sb.push_back('{8'(1 << e), 1'b0, e + 1});
      launch(e, 1'b0, k, bc, r, er, bz);
      x = sb.pop_front();
      nchk++;
      if (k !== x.lat || bc !== e + 1 || bz !== 1'b0) begin
        nfail++;
        $display("FAIL sweep_lat e=%0d got k=%0d busy=%0d bz=%b want k=%0d busy=%0d bz=0",
                 e, k, bc, bz, x.lat, e + 1);
      end
      nchk++;
      if (r !== x.res || er !== x.er) begin
        nfail++;
        $display("FAIL sweep_res e=%0d got %h/%b want %h/%b", e, r, er, x.res, x.er);
      end
      nchk++;
      if (log2_of(r) !== e) begin
        nfail++;
        $display("FAIL loopback e=%0d got %0d want %0d", e, log2_of(r), e);
      end
    end
  endtask

  task automatic test_ignore;
    int pulses = 0; logic [7:0] r = '0; exp_t x;
    sb.push_back('{8'h20, 1'b0, 6});
    @(negedge clk);
    start = 1'b1; exponent = 3'd5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = (i >= 0 && i < 3);
      exponent = 3'd2;
      if (done) begin pulses++; r = result; end
    end
    start = 1'b0;
    x = sb.pop_front();
    nchk++;
    if (pulses !== 1 || r !== x.res) begin
      nfail++;
      $display("FAIL ignore got pulses=%0d r=%h want 1/%h", pulses, r, x.res);
    end
  endtask

  task automatic test_back_to_back;
    int k1 = -1, k2 = -1; logic [7:0] r1 = '0, r2 = '0; exp_t x;
    sb.push_back('{8'h80, 1'b0, 8});
    sb.push_back('{8'h02, 1'b0, 11});
    @(negedge clk);
    start = 1'b1; exponent = 3'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exponent = 3'd1;
      if (done) begin
        if (k1 < 0) begin k1 = i; r1 = result; end
        else begin k2 = i; r2 = result; end
      end
      if (k1 >= 0 && i > k1) start = 1'b0;
    end
    start = 1'b0;
    x = sb.pop_front();
    nchk++;
    if (k1 !== x.lat || r1 !== x.res) begin
      nfail++;
      $display("FAIL b2b_first got k=%0d r=%h want k=%0d r=%h", k1, r1, x.lat, x.res);
    end
    x = sb.pop_front();
    nchk++;
    if (k2 !== x.lat || r2 !== x.res) begin
      nfail++;
      $display("FAIL b2b_second got k=%0d r=%h want k=%0d r=%h", k2, r2, x.lat, x.res);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0, k, bc; logic [7:0] r; logic er, bz; exp_t x;
    sb.push_back('{8'h40, 1'b0, 7});
    @(negedge clk);
    start = 1'b1; exponent = 3'd6;
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, done, result, err} !== 11'h0) begin
      nfail++;
      $display("FAIL midreset_outs got b=%b d=%b r=%h e=%b want 0", busy, done, result, err);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    nchk++;
    if (pulses !== 0) begin
      nfail++;
      $display("FAIL midreset_nodone got %0d pulses want 0", pulses);
    end
    sb.push_back('{8'h08, 1'b0, 4});
    launch(3, 1'b0, k, bc, r, er, bz);
    x = sb.pop_front();
    nchk++;
    if (k !== x.lat || r !== x.res || er !== x.er) begin
      nfail++;
      $display("FAIL midreset_after got k=%0d r=%h e=%b want k=%0d r=%h e=%b",
               k, r, er, x.lat, x.res, x.er);
    end
  endtask

  task automatic test_narrow;
    int k, bc; logic [7:0] r; logic er, bz; exp_t x;
    sb.push_back('{8'h00, 1'b1, 0});
    launch(6, 1'b1, k, bc, r, er, bz);
    x = sb.pop_front();
    nchk++;
    if (k !== x.lat || r !== x.res || er !== x.er || bc !== 0) begin
      nfail++;
      $display("FAIL narrow_err got k=%0d r=%h e=%b busy=%0d want k=%0d r=%h e=%b busy=0",
               k, r, er, bc, x.lat, x.res, x.er);
    end
    @(negedge clk);
    nchk++;
    if (err4 !== 1'b1 || done4 !== 1'b0) begin
      nfail++;
      $display("FAIL narrow_hold got err=%b done=%b want 1/0", err4, done4);
    end
    sb.push_back('{8'h04, 1'b0, 3});
    launch(2, 1'b1, k, bc, r, er, bz);
    x = sb.pop_front();
    nchk++;
    if (k !== x.lat || r !== x.res || er !== x.er) begin
      nfail++;
      $display("FAIL narrow_ok got k=%0d r=%h e=%b want k=%0d r=%h e=%b",
               k, r, er, x.lat, x.res, x.er);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
